video_input: RTL

VIDEO_INPUT -- requirements
Module: video_input

---
 rtl/video_input_if.sv | 22 ++
 rtl/video_input.sv | 91 +++++++++
 2 files changed

// File: rtl/video_input_if.sv
// Pixel-stream and packed-word handshake between a pixel source/word consumer and video_input.
interface video_input_if;
  logic        screen_control;
  logic [3:0]  data_in;
  logic        data_in_en;
  logic        line_start;
  logic [23:0] data_out;
  logic        data_out_valid;
  logic        data_out_ack;
  logic        overflow;
  logic        overflow_clear;

  modport slave (
    input  screen_control, data_in, data_in_en, line_start, data_out_ack, overflow_clear,
    output data_out, data_out_valid, overflow
  );

  modport master (
    output screen_control, data_in, data_in_en, line_start, data_out_ack, overflow_clear,
    input  data_out, data_out_valid, overflow
  );
endinterface

// File: rtl/video_input.sv
// Packs six serial 4-bit pixels into a 24-bit word, in linear or pair-swapped nibble order,
// and hands it to a single-entry holding register with drop-on-full overflow reporting.
module video_input (
  input  logic          clk,
  input  logic          rst,
  video_input_if.slave  bus
);
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned LAST_IX = 5;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ctrl_q, ctrl_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  pos;
  logic              cur_ctrl;
  logic [WORD_W-1:0] packed_word;
  logic              complete;
  logic              transfer;
  logic              drop;

  // line_start restarts the word at index 0; the control bit is taken fresh at index 0 only.
  always_comb begin
    idx_d       = idx_q;
    word_d      = word_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;
    cur_idx     = bus.line_start ? '0 : idx_q;
    cur_ctrl    = (cur_idx == '0) ? bus.screen_control : ctrl_q;
    pos         = cur_ctrl ? cur_idx : (cur_idx ^ IDX_W'(1));
    packed_word = (cur_idx == '0) ? '0 : word_q;
    packed_word[{pos, 2'b00} +: PIX_W] = bus.data_in;
    complete    = bus.data_in_en && (cur_idx == IDX_W'(LAST_IX));
    transfer    = complete && (!valid_q || bus.data_out_ack);
    drop        = complete && valid_q && !bus.data_out_ack;

    if (bus.line_start) begin
      idx_d  = '0;
      word_d = '0;
    end
    if (bus.data_in_en) begin
      ctrl_d = cur_ctrl;
      if (complete) begin
        idx_d  = '0;
        word_d = '0;
      end else begin
        idx_d  = IDX_W'(cur_idx + IDX_W'(1));
        word_d = packed_word;
      end
    end

    if (transfer) begin
      valid_d = 1'b1;
      data_d  = packed_word;
    end else if (bus.data_out_ack) begin
      valid_d = 1'b0;
    end

    ovf_d = drop | (ovf_q & ~bus.overflow_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      word_q  <= '0;
      ctrl_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      word_q  <= word_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.data_out       = data_q;
  assign bus.data_out_valid = valid_q;
  assign bus.overflow       = ovf_q;
endmodule
